// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin arbiter that feeds one word per cycle into an
// external, non-resettable delay line and tracks each word with a {valid, id}
// tag pipeline of matching latency, so the returned word comes back labelled
// with its requester.
// Optional feature macro: DELAY_ARB_PRIORITY0_EN -- when defined, requester 0
// wins whenever it is valid and requesters 1..NUM_REQ-1 share round-robin.
module delay_arbiter #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int LATENCY   = 3
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         dly_enable,
    output logic [BIT_WIDTH-1:0]         dly_in_data,
    input  logic [BIT_WIDTH-1:0]         dly_out_data,
    output logic                         out_valid,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic [BIT_WIDTH-1:0]         out_data,
    output logic                         busy
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam int              CNT_W   = $clog2(LATENCY + 1);
    localparam logic [ID_W:0]   NREQ    = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    // Round-robin pointer: index searched first on the next arbitration
    logic [ID_W-1:0]    ptr;

    // Arbitration results
    logic [NUM_REQ-1:0] cand;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W:0]      slot;
    logic               xfer;

    // Tag pipeline travelling alongside the external delay line
    logic [LATENCY-1:0] tag_vld_p;
    logic [ID_W-1:0]    tag_id_p [LATENCY];

    // Number of valid tags currently in flight
    logic [CNT_W-1:0]   cnt;

    // Find the first eligible requester at or above the pointer, wrapping
    always_comb begin
        cand    = req_valid;
        gnt_any = 1'b0;
        gnt_id  = '0;
        slot    = '0;
`ifdef DELAY_ARB_PRIORITY0_EN
        // Requester 0 is handled by the override below, not by the rotation
        cand[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, ptr} + (ID_W + 1)'(k);
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            if (!gnt_any && cand[slot[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = slot[ID_W-1:0];
            end
        end
`ifdef DELAY_ARB_PRIORITY0_EN
        if (req_valid[0]) begin
            gnt_any = 1'b1;
            gnt_id  = '0;
        end
`endif
    end

    // Qualify the grant into a transfer and steer the winner's data out
    always_comb begin
        xfer        = gnt_any && enable && !flush && !rst;
        req_ready   = '0;
        dly_in_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && (gnt_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                dly_in_data  = req_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign dly_enable = enable;
    assign out_valid  = tag_vld_p[LATENCY-1];
    assign out_id     = tag_id_p[LATENCY-1];
    assign out_data   = dly_out_data;
    assign busy       = (cnt != '0);

    // Advance the pointer past the requester that just transferred
    always_ff @(posedge clock) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
    end

    // Shift tags in lock-step with the delay line; flush kills every valid
    always_ff @(posedge clock) begin
        if (rst) begin
            tag_vld_p <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_id_p[k] <= '0;
            end
        end else begin
            if (enable) begin
                tag_vld_p[0] <= xfer;
                tag_id_p[0]  <= gnt_id;
                for (int k = 1; k < LATENCY; k++) begin
                    tag_vld_p[k] <= tag_vld_p[k-1];
                    tag_id_p[k]  <= tag_id_p[k-1];
                end
            end
            // Flush acts even while frozen and overrides the shift above
            if (flush) begin
                tag_vld_p <= '0;
            end
        end
    end

    // In-flight count: entries in, words out the far end
    always_ff @(posedge clock) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (enable) begin
            if (xfer && !out_valid) begin
                cnt <= cnt + 1'b1;
            end else if (!xfer && out_valid) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: directed table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model. The external
// delay line is modelled here as an enable-gated shift register.
module tb_delay_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int L   = 3;
    localparam int IDW = 2;

    logic           clock = 1'b0;
    logic           rst;
    logic           enable;
    logic           flush;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           dly_enable;
    logic [W-1:0]   dly_in_data;
    logic [W-1:0]   dly_out_data;
    logic           out_valid;
    logic [IDW-1:0] out_id;
    logic [W-1:0]   out_data;
    logic           busy;

    int errors;
    int checks;

    always #5 clock = ~clock;

    delay_arbiter #(.BIT_WIDTH(W), .NUM_REQ(N), .LATENCY(L)) dut (
        .clock        (clock),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .dly_enable   (dly_enable),
        .dly_in_data  (dly_in_data),
        .dly_out_data (dly_out_data),
        .out_valid    (out_valid),
        .out_id       (out_id),
        .out_data     (out_data),
        .busy         (busy)
    );

    // External delay line: L enabled cycles, never reset
    logic [W-1:0] dl [L];
    always @(posedge clock) begin
        if (dly_enable) begin
            dl[0] <= dly_in_data;
            for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
        end
    end
    assign dly_out_data = dl[L-1];

    // Reference model: pointer plus a queue of in-flight words with the
    // number of enabled edges each has seen since acceptance.
    int           m_ptr;
    int           q_id [$];
    int           q_age [$];
    logic [W-1:0] q_dat [$];

    function automatic int mgrant(logic [N-1:0] v, int p);
`ifdef DELAY_ARB_PRIORITY0_EN
        if (v[0]) return 0;
        v[0] = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        q_id.delete();
        q_age.delete();
        q_dat.delete();
    endtask

    task automatic model_update();
        int g;
        bit x;
        if (rst) begin
            model_clear();
            m_ptr = 0;
            return;
        end
        g = mgrant(req_valid, m_ptr);
        x = enable && !flush && (g >= 0);
        if (enable) begin
            for (int i = q_age.size() - 1; i >= 0; i--) begin
                if (q_age[i] == L) begin
                    q_id.delete(i);
                    q_age.delete(i);
                    q_dat.delete(i);
                end else begin
                    q_age[i] = q_age[i] + 1;
                end
            end
        end
        if (flush) begin
            model_clear();
        end else if (x) begin
            q_id.push_back(g);
            q_age.push_back(1);
            q_dat.push_back(req_data[g*W +: W]);
        end
        if (x) m_ptr = (g + 1) % N;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int           g;
        bit           x;
        bit           ev;
        int           eid;
        logic [W-1:0] ed;
        g   = mgrant(req_valid, m_ptr);
        x   = !rst && enable && !flush && (g >= 0);
        ev  = 1'b0;
        eid = 0;
        ed  = '0;
        for (int i = 0; i < q_age.size(); i++) begin
            if (q_age[i] == L) begin
                ev  = 1'b1;
                eid = q_id[i];
                ed  = q_dat[i];
            end
        end
        chk("rnd_ready", 32'(req_ready), x ? (32'd1 << g) : 32'd0);
        chk("rnd_dly_enable", 32'(dly_enable), 32'(enable));
        chk("rnd_dly_in_data", 32'(dly_in_data), x ? 32'(req_data[g*W +: W]) : 32'd0);
        chk("rnd_out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            chk("rnd_out_id", 32'(out_id), 32'(eid));
            chk("rnd_out_data", 32'(out_data), 32'(ed));
        end
        chk("rnd_busy", 32'(busy), 32'(q_age.size() != 0));
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic [N-1:0] ready;
        logic         ov;
        int           id;
        logic         bsy;
    } row_t;

    row_t tbl [11];

    initial begin
        errors = 0;
        checks = 0;
        m_ptr  = 0;

`ifdef DELAY_ARB_PRIORITY0_EN
        tbl[0]  = '{4'b0111, 4'b0001, 1'b0, 0, 1'b0};
        tbl[1]  = '{4'b0111, 4'b0001, 1'b0, 0, 1'b1};
        tbl[2]  = '{4'b0111, 4'b0001, 1'b0, 0, 1'b1};
        tbl[3]  = '{4'b0111, 4'b0001, 1'b1, 0, 1'b1};
        tbl[4]  = '{4'b0110, 4'b0010, 1'b1, 0, 1'b1};
        tbl[5]  = '{4'b0110, 4'b0100, 1'b1, 0, 1'b1};
        tbl[6]  = '{4'b0110, 4'b0010, 1'b1, 0, 1'b1};
        tbl[7]  = '{4'b0110, 4'b0100, 1'b1, 1, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 2, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 2, 1'b1};
`else
        tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0010, 1'b0, 0, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0100, 1'b0, 0, 1'b1};
        tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 0, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 1, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 2, 1'b1};
        tbl[6]  = '{4'b1111, 4'b0100, 1'b1, 3, 1'b1};
        tbl[7]  = '{4'b1111, 4'b1000, 1'b1, 0, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 2, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 3, 1'b1};
`endif

        // Reset behaviour: no accept while rst is high, outputs cleared
        rst       = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        req_valid = '1;
        req_data  = 32'h13121110;
        #2;
        chk("rst_ready_first", 32'(req_ready), 32'd0);
        step();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready_held", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Table: steady requests, rotation and latency of the returned ids
        for (int r = 0; r < 11; r++) begin
            req_valid = tbl[r].vld;
            #2;
            chk("tbl_ready", 32'(req_ready), 32'(tbl[r].ready));
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[r].ov));
            if (tbl[r].ov) begin
                chk("tbl_out_id", 32'(out_id), 32'(tbl[r].id));
                chk("tbl_out_data", 32'(out_data), 32'h10 + 32'(tbl[r].id));
            end
            chk("tbl_busy", 32'(busy), 32'(tbl[r].bsy));
            step();
        end

        // Single word from requester 2 with a two-cycle stall mid-flight
        do_reset();
        req_data  = 32'h00A50000;
        req_valid = 4'b0100;
        #2;
        chk("stall_accept", 32'(req_ready), 32'b0100);
        chk("stall_din", 32'(dly_in_data), 32'hA5);
        step();
        req_valid = '0;
        #2;
        chk("stall_ov_c1", 32'(out_valid), 32'd0);
        chk("stall_busy_c1", 32'(busy), 32'd1);
        step();
        for (int s = 0; s < 2; s++) begin
            enable    = 1'b0;
            req_valid = 4'b1111;
            #2;
            chk("stall_ready_frozen", 32'(req_ready), 32'd0);
            chk("stall_ov_frozen", 32'(out_valid), 32'd0);
            chk("stall_dly_enable", 32'(dly_enable), 32'd0);
            step();
        end
        enable    = 1'b1;
        req_valid = '0;
        #2;
        chk("stall_ov_c4", 32'(out_valid), 32'd0);
        step();
        #2;
        chk("stall_ov", 32'(out_valid), 32'd1);
        chk("stall_id", 32'(out_id), 32'd2);
        chk("stall_data", 32'(out_data), 32'hA5);
        step();
        #2;
        chk("stall_ov_after", 32'(out_valid), 32'd0);
        chk("stall_busy_after", 32'(busy), 32'd0);

        // Three words accepted, then a flush that also blocks a grant
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b0001;
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("flush_accept", 32'(req_ready), 32'b0001);
            step();
        end
        flush = 1'b1;
        #2;
        chk("flush_ready", 32'(req_ready), 32'd0);
        chk("flush_din", 32'(dly_in_data), 32'd0);
        step();
        flush     = 1'b0;
        req_valid = '0;
        #2;
        chk("flush_busy", 32'(busy), 32'd0);
        for (int s = 0; s < 4; s++) begin
            chk("flush_no_ov", 32'(out_valid), 32'd0);
            step();
            #2;
        end

        // Reset with two words in flight: they vanish, pointer returns to 0
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b0011;
        #2;
        chk("midrst_g0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0010;
        #2;
        chk("midrst_g1", 32'(req_ready), 32'b0010);
        step();
        rst       = 1'b1;
        req_valid = 4'b0011;
        #2;
        chk("midrst_ready_in_rst", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        #2;
        chk("midrst_first_grant", 32'(req_ready), 32'b0001);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ov_c3", 32'(out_valid), 32'd0);
        step();
        req_valid = '0;
        #2;
        chk("midrst_ov_c4", 32'(out_valid), 32'd0);
        step();
        #2;
        chk("midrst_ov_c5", 32'(out_valid), 32'd0);
        step();
        #2;
        chk("midrst_ov_new", 32'(out_valid), 32'd1);
        chk("midrst_id_new", 32'(out_id), 32'd0);
        chk("midrst_data_new", 32'(out_data), 32'h11);
        step();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 127) == 0);
            req_valid = N'($urandom);
            req_data  = $urandom;
            #2;
            check_model();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
